// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the MIPS-lite instruction-fetch stage.
package fetch_stage_pkg;

  localparam int unsigned PcWidth = 32;
  localparam logic [31:0] NopWordDef = 32'h0000_0000;

  // Fetch controller states.
  typedef enum logic [1:0] {
    FsFetch = 2'd0,
    FsHold  = 2'd1,
    FsDrain = 2'd2
  } fetch_state_e;

  // Next-PC source select.
  typedef enum logic [1:0] {
    PcHold   = 2'd0,
    PcSeq    = 2'd1,
    PcTarget = 2'd2,
    PcBuf    = 2'd3
  } pc_sel_e;

  // Instruction addresses are word aligned; low bits of a target are dropped.
  function automatic logic [PcWidth-1:0] word_align(input logic [PcWidth-1:0] addr);
    return {addr[PcWidth-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic               imem_req;
  logic [PcWidth-1:0] imem_addr;
  logic               imem_rdy;
  logic [31:0]        imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdy,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdy,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_stage_pc_next_sel.sv
// Combinational next-PC select: hold, sequential, redirect target or buffered target.
module fetch_stage_pc_next_sel
  import fetch_stage_pkg::*;
(
  input  pc_sel_e            sel,
  input  logic [PcWidth-1:0] pc,
  input  logic [PcWidth-1:0] target,
  input  logic [PcWidth-1:0] redir_buf,
  output logic [PcWidth-1:0] pc_next,
  output logic [PcWidth-1:0] pc_plus4
);

  // Select the PC source; the +4 wraps modulo 2^32.
  always_comb begin
    pc_plus4 = pc + PcWidth'(4);
    pc_next  = pc;
    unique case (sel)
      PcHold:   pc_next = pc;
      PcSeq:    pc_next = pc_plus4;
      PcTarget: pc_next = target;
      PcBuf:    pc_next = redir_buf;
      default:  pc_next = pc;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register, one-entry skid buffer and
// redirect drain. Build option DELAY_SLOT_EN keeps the word fetched in a redirect
// cycle (MIPS branch-delay slot) instead of squashing it.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [PcWidth-1:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0]        NOP_WORD = NopWordDef
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               br_taken,
  input  logic [PcWidth-1:0] br_target,
  input  logic               jmp,
  input  logic [PcWidth-1:0] jmp_target,
  fetch_stage_if.master      imem,
  output logic               id_valid,
  output logic [31:0]        id_instr,
  output logic [PcWidth-1:0] id_pc,
  output logic [PcWidth-1:0] id_pc4
);

  fetch_state_e       r_state;
  logic [PcWidth-1:0] r_pc;
  logic               r_req;
  logic [PcWidth-1:0] r_redir_buf;
  logic [31:0]        r_skid_instr;
  logic [PcWidth-1:0] r_skid_pc;
  logic               r_id_valid;
  logic [31:0]        r_id_instr;
  logic [PcWidth-1:0] r_id_pc;
  logic [PcWidth-1:0] r_id_pc4;

  logic               w_redirect;
  logic [PcWidth-1:0] w_target;
  logic               w_rdy;
  pc_sel_e            w_pc_sel;
  logic [PcWidth-1:0] w_pc_next;
  logic [PcWidth-1:0] w_pc_plus4;

  // A stalled decode cannot redirect; jump has priority over branch.
  assign w_redirect = (jmp | br_taken) & ~stall;
  assign w_target   = word_align(jmp ? jmp_target : br_target);
  // A response only counts while our request is actually on the bus.
  assign w_rdy      = imem.imem_rdy & r_req;

  assign imem.imem_req  = r_req;
  assign imem.imem_addr = r_pc;

  assign id_valid = r_id_valid;
  assign id_instr = r_id_instr;
  assign id_pc    = r_id_pc;
  assign id_pc4   = r_id_pc4;

  // Decide where the PC goes this cycle.
  always_comb begin
    w_pc_sel = PcHold;
    unique case (r_state)
      FsFetch: begin
        if (w_rdy) begin
          w_pc_sel = w_redirect ? PcTarget : PcSeq;
        end else if (w_redirect && !r_req) begin
          // No request in flight yet, so nothing needs draining.
          w_pc_sel = PcTarget;
        end
      end
      FsHold: begin
        if (w_redirect) w_pc_sel = PcTarget;
      end
      FsDrain: begin
        if (w_rdy) w_pc_sel = w_redirect ? PcTarget : PcBuf;
      end
      default: w_pc_sel = PcHold;
    endcase
  end

  fetch_stage_pc_next_sel u_pc_next_sel (
    .sel       (w_pc_sel),
    .pc        (r_pc),
    .target    (w_target),
    .redir_buf (r_redir_buf),
    .pc_next   (w_pc_next),
    .pc_plus4  (w_pc_plus4)
  );

  // Fetch FSM, skid buffer, PC and IF/ID register with registered imem_req.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= FsFetch;
      r_pc         <= RESET_PC;
      r_req        <= 1'b0;
      r_redir_buf  <= '0;
      r_skid_instr <= NOP_WORD;
      r_skid_pc    <= '0;
      r_id_valid   <= 1'b0;
      r_id_instr   <= NOP_WORD;
      r_id_pc      <= '0;
      r_id_pc4     <= '0;
    end else begin
      r_pc <= w_pc_next;
      unique case (r_state)
        FsFetch: begin
          r_req <= 1'b1;
          if (w_rdy && stall) begin
            r_skid_instr <= imem.imem_rdata;
            r_skid_pc    <= r_pc;
            r_state      <= FsHold;
            r_req        <= 1'b0;
          end else if (w_rdy) begin
`ifdef DELAY_SLOT_EN
            r_id_valid <= 1'b1;
            r_id_instr <= imem.imem_rdata;
            r_id_pc    <= r_pc;
            r_id_pc4   <= w_pc_plus4;
`else
            if (w_redirect) begin
              r_id_valid <= 1'b0;
              r_id_instr <= NOP_WORD;
            end else begin
              r_id_valid <= 1'b1;
              r_id_instr <= imem.imem_rdata;
              r_id_pc    <= r_pc;
              r_id_pc4   <= w_pc_plus4;
            end
`endif
          end else if (!stall) begin
            r_id_valid <= 1'b0;
            r_id_instr <= NOP_WORD;
            if (w_redirect && r_req) begin
              r_redir_buf <= w_target;
              r_state     <= FsDrain;
            end
          end
        end
        FsHold: begin
          if (!stall) begin
            r_state <= FsFetch;
            r_req   <= 1'b1;
`ifdef DELAY_SLOT_EN
            r_id_valid <= 1'b1;
            r_id_instr <= r_skid_instr;
            r_id_pc    <= r_skid_pc;
            r_id_pc4   <= r_skid_pc + PcWidth'(4);
`else
            if (w_redirect) begin
              r_id_valid <= 1'b0;
              r_id_instr <= NOP_WORD;
            end else begin
              r_id_valid <= 1'b1;
              r_id_instr <= r_skid_instr;
              r_id_pc    <= r_skid_pc;
              r_id_pc4   <= r_skid_pc + PcWidth'(4);
            end
`endif
          end
        end
        FsDrain: begin
          // Latest redirect wins while the old request is still outstanding.
          if (w_redirect) r_redir_buf <= w_target;
          if (w_rdy) begin
`ifdef DELAY_SLOT_EN
            if (stall) begin
              r_skid_instr <= imem.imem_rdata;
              r_skid_pc    <= r_pc;
              r_state      <= FsHold;
              r_req        <= 1'b0;
            end else begin
              r_id_valid <= 1'b1;
              r_id_instr <= imem.imem_rdata;
              r_id_pc    <= r_pc;
              r_id_pc4   <= w_pc_plus4;
              r_state    <= FsFetch;
            end
`else
            r_state <= FsFetch;
            if (!stall) begin
              r_id_valid <= 1'b0;
              r_id_instr <= NOP_WORD;
            end
`endif
          end
        end
        default: begin
          r_state <= FsFetch;
          r_req   <= 1'b1;
        end
      endcase
    end
  end

endmodule
